// File: rtl/seg7_scan_decoder_if.sv
// Purpose : display-side bus (segments + digit select) and decoded result of seg7_scan_decoder.
// Latency : none, wires only.
// Backpressure: none; the display bus is free-running and the results are pulses/levels.
// Ports   : master drives led_signal/select_led and observes the results; slave is the decoder.
interface seg7_scan_decoder_if;
   logic [6:0] led_signal;   // {g,f,e,d,c,b,a}, bit0 = a
   logic [1:0] select_led;   // digit-select lines
   logic [4:0] value;        // tens*10 + ones
   logic [3:0] bcd_tens;
   logic [3:0] bcd_ones;
   logic       valid;        // one-cycle pulse on output change
   logic       locked;       // first stable reading committed
   logic       seg_err;      // one-cycle pulse on a bad digit

   modport master (
      output led_signal, select_led,
      input  value, bcd_tens, bcd_ones, valid, locked, seg_err
   );

   modport slave (
      input  led_signal, select_led,
      output value, bcd_tens, bcd_ones, valid, locked, seg_err
   );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Purpose : decode a two-digit multiplexed 7-segment bus back to BCD/binary, debounced over scans.
// Latency : bus registered once; a scan commits to the outputs 2 edges after its ones sample.
// Backpressure: none; the decoder only observes the bus and never stalls it.
// Ports   : clk, rst (async, active high); bus.slave carries led_signal/select_led in and
//           value, bcd_tens, bcd_ones, valid, locked, seg_err out (all outputs registered).
module seg7_scan_decoder #(
   parameter int unsigned STABLE_SCANS    = 4,
   parameter logic [1:0]  SEL_TENS        = 2'b10,
   parameter logic [1:0]  SEL_ONES        = 2'b01,
   parameter bit          SEG_ACTIVE_HIGH = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   seg7_scan_decoder_if.slave   bus
);

   localparam logic [3:0] STABLE_MAX = 4'(STABLE_SCANS);

   typedef enum logic [1:0] {IDLE, GOT_TENS, COMPARE} state_t;

   // Returns {ok, digit} for an active-high segment pattern.
   function automatic logic [4:0] seg_decode(input logic [6:0] s);
      case (s)
         7'h3F:   return {1'b1, 4'd0};
         7'h06:   return {1'b1, 4'd1};
         7'h5B:   return {1'b1, 4'd2};
         7'h4F:   return {1'b1, 4'd3};
         7'h66:   return {1'b1, 4'd4};
         7'h6D:   return {1'b1, 4'd5};
         7'h7D:   return {1'b1, 4'd6};
         7'h07:   return {1'b1, 4'd7};
         7'h7F:   return {1'b1, 4'd8};
         7'h6F:   return {1'b1, 4'd9};
         default: return 5'd0;
      endcase
   endfunction

   state_t     state_q, state_d;
   logic [6:0] led_q, led_d;
   logic [1:0] sel_q, sel_d;
   logic [1:0] sel_prev_q, sel_prev_d;
   logic [1:0] settle_q, settle_d;
   logic [3:0] tens_cand_q, tens_cand_d;
   logic [3:0] ones_cand_q, ones_cand_d;
   logic [3:0] prev_tens_q, prev_tens_d;
   logic [3:0] prev_ones_q, prev_ones_d;
   logic [3:0] stable_q, stable_d;
   logic [4:0] value_q, value_d;
   logic [3:0] tens_q, tens_d;
   logic [3:0] ones_q, ones_d;
   logic       valid_q, valid_d;
   logic       locked_q, locked_d;
   logic       seg_err_q, seg_err_d;

   logic [6:0] seg_lit;
   logic [4:0] dec;
   logic       sel_is_tens, sel_is_ones, sample;
   logic       tens_ok, ones_ok;
   logic [3:0] tens_digit;
   logic [3:0] stable_nx;

   assign seg_lit     = SEG_ACTIVE_HIGH ? led_q : ~led_q;
   assign dec         = seg_decode(seg_lit);
   assign sel_is_tens = (sel_q == SEL_TENS);
   assign sel_is_ones = (sel_q == SEL_ONES);
   // One sample per dwell: taken on the second registered cycle of a steady code, which
   // skips the cycle where the segments may still show the previous digit.
   assign sample      = (sel_is_tens || sel_is_ones) && (sel_q == sel_prev_q) && (settle_q == 2'd1);
   // A blanked leading zero (all segments dark) is a legal tens digit.
   assign tens_ok     = (seg_lit == 7'h00) || (dec[4] && (dec[3:0] <= 4'd1));
   assign tens_digit  = (seg_lit == 7'h00) ? 4'd0 : dec[3:0];
   assign ones_ok     = dec[4];

   always_comb begin
      led_d       = bus.led_signal;
      sel_d       = bus.select_led;
      sel_prev_d  = sel_q;
      settle_d    = settle_q;
      state_d     = state_q;
      tens_cand_d = tens_cand_q;
      ones_cand_d = ones_cand_q;
      prev_tens_d = prev_tens_q;
      prev_ones_d = prev_ones_q;
      stable_d    = stable_q;
      value_d     = value_q;
      tens_d      = tens_q;
      ones_d      = ones_q;
      valid_d     = 1'b0;
      locked_d    = locked_q;
      seg_err_d   = 1'b0;
      stable_nx   = stable_q;

      if (!(sel_is_tens || sel_is_ones))  settle_d = 2'd0;
      else if (sel_q != sel_prev_q)       settle_d = 2'd1;
      else if (settle_q != 2'd2)          settle_d = settle_q + 2'd1;

      // Only samples the FSM consumes are checked; a ones sample arriving in IDLE is
      // dropped unseen because a scan must start with tens.
      case (state_q)
         IDLE: begin
            if (sample && sel_is_tens) begin
               if (tens_ok) begin
                  tens_cand_d = tens_digit;
                  state_d     = GOT_TENS;
               end else begin
                  seg_err_d = 1'b1;
                  stable_d  = 4'd0;
               end
            end
         end
         GOT_TENS: begin
            if (sample && sel_is_tens) begin
               if (tens_ok) begin
                  tens_cand_d = tens_digit;
               end else begin
                  seg_err_d = 1'b1;
                  stable_d  = 4'd0;
                  state_d   = IDLE;
               end
            end else if (sample && sel_is_ones) begin
               if (ones_ok) begin
                  ones_cand_d = dec[3:0];
                  state_d     = COMPARE;
               end else begin
                  seg_err_d = 1'b1;
                  stable_d  = 4'd0;
                  state_d   = IDLE;
               end
            end
         end
         COMPARE: begin
            state_d = IDLE;
            if ((tens_cand_q == prev_tens_q) && (ones_cand_q == prev_ones_q)) begin
               stable_nx = (stable_q >= STABLE_MAX) ? STABLE_MAX : stable_q + 4'd1;
            end else begin
               stable_nx   = 4'd1;
               prev_tens_d = tens_cand_q;
               prev_ones_d = ones_cand_q;
            end
            stable_d = stable_nx;
            // Errors are only raised in the sampling states, so a commit here can never
            // coincide with one; the guard keeps that priority explicit.
            if (!seg_err_d && (stable_nx == STABLE_MAX) &&
                (!locked_q || (tens_cand_q != tens_q) || (ones_cand_q != ones_q))) begin
               tens_d   = tens_cand_q;
               ones_d   = ones_cand_q;
               value_d  = ({1'b0, tens_cand_q} * 5'd10) + {1'b0, ones_cand_q};
               valid_d  = 1'b1;
               locked_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         led_q       <= 7'd0;
         sel_q       <= 2'd0;
         sel_prev_q  <= 2'd0;
         settle_q    <= 2'd0;
         tens_cand_q <= 4'd0;
         ones_cand_q <= 4'd0;
         prev_tens_q <= 4'd0;
         prev_ones_q <= 4'd0;
         stable_q    <= 4'd0;
         value_q     <= 5'd0;
         tens_q      <= 4'd0;
         ones_q      <= 4'd0;
         valid_q     <= 1'b0;
         locked_q    <= 1'b0;
         seg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         led_q       <= led_d;
         sel_q       <= sel_d;
         sel_prev_q  <= sel_prev_d;
         settle_q    <= settle_d;
         tens_cand_q <= tens_cand_d;
         ones_cand_q <= ones_cand_d;
         prev_tens_q <= prev_tens_d;
         prev_ones_q <= prev_ones_d;
         stable_q    <= stable_d;
         value_q     <= value_d;
         tens_q      <= tens_d;
         ones_q      <= ones_d;
         valid_q     <= valid_d;
         locked_q    <= locked_d;
         seg_err_q   <= seg_err_d;
      end
   end

   assign bus.value    = value_q;
   assign bus.bcd_tens = tens_q;
   assign bus.bcd_ones = ones_q;
   assign bus.valid    = valid_q;
   assign bus.locked   = locked_q;
   assign bus.seg_err  = seg_err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Purpose : scan-level randomized check of seg7_scan_decoder, active-high and inverted-bus instances.
// Latency : each scan is followed by an idle gap so its commit/error pulse lands before checking.
// Backpressure: none; the bench drives the display bus freely.
module tb_seg7_scan_decoder;

   localparam int         N     = 4;
   localparam logic [1:0] TENS  = 2'b10;
   localparam logic [1:0] ONES  = 2'b01;
   localparam logic [1:0] OFF   = 2'b00;
   localparam logic [6:0] JUNK  = 7'h49;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seg7_scan_decoder_if bus_h ();
   seg7_scan_decoder_if bus_l ();

   seg7_scan_decoder #(.STABLE_SCANS(N)) dut_h (.clk(clk), .rst(rst), .bus(bus_h));
   seg7_scan_decoder #(.STABLE_SCANS(N), .SEG_ACTIVE_HIGH(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

   int n_pass = 0;
   int n_total = 0;

   // Observed pulse counts, sampled mid-cycle.
   int vh = 0, vl = 0, eh = 0, el = 0;
   always @(negedge clk) begin
      if (bus_h.valid)   vh++;
      if (bus_l.valid)   vl++;
      if (bus_h.seg_err) eh++;
      if (bus_l.seg_err) el++;
   end

   // Scan-level reference: displayed pair, lock flag, run length of identical scans.
   logic [6:0] seg_tab [10];
   int m_run = 0, m_pt = 0, m_po = 0, m_dt = 0, m_do = 0;
   bit m_lk = 1'b0;
   int m_v = 0, m_e = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_total++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   function automatic int dec(input logic [6:0] p, input bit is_tens);
      if (is_tens && p == 7'h00) return 0;
      for (int i = 0; i < 10; i++) if (seg_tab[i] == p) return i;
      return -1;
   endfunction

   task automatic model_scan(input logic [6:0] tp, input logic [6:0] op);
      int t, o;
      t = dec(tp, 1'b1);
      o = dec(op, 1'b0);
      if (t < 0 || t > 1 || o < 0) begin
         m_e++;
         m_run = 0;
      end else begin
         if (m_run > 0 && t == m_pt && o == m_po) m_run = (m_run < N) ? m_run + 1 : N;
         else begin
            m_run = 1;
            m_pt  = t;
            m_po  = o;
         end
         if (m_run == N && (!m_lk || t != m_dt || o != m_do)) begin
            m_v++;
            m_dt = t;
            m_do = o;
            m_lk = 1'b1;
         end
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_dt = 0; m_do = 0; m_lk = 1'b0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".value_h"},  int'(bus_h.value),    m_dt * 10 + m_do);
      chk({tag, ".tens_h"},   int'(bus_h.bcd_tens), m_dt);
      chk({tag, ".ones_h"},   int'(bus_h.bcd_ones), m_do);
      chk({tag, ".locked_h"}, int'(bus_h.locked),   int'(m_lk));
      chk({tag, ".nvalid_h"}, vh, m_v);
      chk({tag, ".nerr_h"},   eh, m_e);
      chk({tag, ".value_l"},  int'(bus_l.value),    m_dt * 10 + m_do);
      chk({tag, ".tens_l"},   int'(bus_l.bcd_tens), m_dt);
      chk({tag, ".ones_l"},   int'(bus_l.bcd_ones), m_do);
      chk({tag, ".locked_l"}, int'(bus_l.locked),   int'(m_lk));
      chk({tag, ".nvalid_l"}, vl, m_v);
      chk({tag, ".nerr_l"},   el, m_e);
   endtask

   // Drive one clock of bus; the inverted instance sees the complemented segments.
   task automatic drive(input logic [1:0] sel, input logic [6:0] pat);
      bus_h.select_led = sel;
      bus_h.led_signal = pat;
      bus_l.select_led = sel;
      bus_l.led_signal = ~pat;
      @(posedge clk);
      #1;
   endtask

   task automatic scan(input string tag, input logic [6:0] tp, input logic [6:0] op,
                       input int dt, input int dn, input bit glitch);
      if (glitch) drive(ONES, JUNK);
      if (glitch) drive(TENS, JUNK);
      repeat (dt) drive(TENS, tp);
      if (glitch) drive(ONES, JUNK);
      repeat (dn) drive(ONES, op);
      if (glitch) drive(TENS, JUNK);
      repeat (4) drive(OFF, 7'h00);
      model_scan(tp, op);
      check_all(tag);
   endtask

   task automatic scans(input string tag, input logic [6:0] tp, input logic [6:0] op,
                        input int n, input bit glitch);
      for (int i = 0; i < n; i++) scan(tag, tp, op, 4, 4, glitch);
   endtask

   initial begin
      logic [6:0] tp, op;
      int reps, kind;
      seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      rst = 1'b1;
      bus_h.select_led = OFF; bus_h.led_signal = 7'h00;
      bus_l.select_led = OFF; bus_l.led_signal = 7'h7F;
      repeat (3) drive(OFF, 7'h00);
      check_all("reset");
      rst = 1'b0;
      drive(OFF, 7'h00);

      scans("s17", 7'h06, 7'h07, 24, 1'b0);
      scans("s18", 7'h06, 7'h7F, 4, 1'b0);
      scans("s19", 7'h06, 7'h6F, 4, 1'b0);
      scans("s00", 7'h3F, 7'h3F, 4, 1'b0);
      scans("s09b", 7'h00, 7'h6F, 4, 1'b0);

      scans("g11", 7'h06, 7'h06, 6, 1'b1);
      scans("g12a", 7'h06, 7'h5B, 1, 1'b1);
      scans("g11b", 7'h06, 7'h06, 3, 1'b1);
      scans("g12b", 7'h06, 7'h5B, 3, 1'b0);
      scans("g11c", 7'h06, 7'h06, 1, 1'b0);
      scans("g12c", 7'h06, 7'h5B, 4, 1'b0);

      scan("err_ones", 7'h06, 7'h49, 4, 4, 1'b0);
      scan("err_tens", 7'h5B, 7'h06, 4, 4, 1'b0);
      scans("after_err", 7'h06, 7'h5B, 2, 1'b0);

      // Asynchronous reset in the middle of a tens dwell.
      drive(TENS, 7'h06);
      drive(TENS, 7'h06);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all("rst_mid");
      drive(TENS, 7'h06);
      drive(OFF, 7'h00);
      rst = 1'b0;
      drive(OFF, 7'h00);
      scans("post_rst", 7'h00, 7'h6F, 3, 1'b0);
      chk("post_rst.no_pulse", vh, 0 + m_v);
      scans("post_rst4", 7'h00, 7'h6F, 1, 1'b0);
      chk("post_rst.locked", int'(bus_h.locked), 1);

      for (int s = 0; s < 40; s++) begin
         reps = $urandom_range(1, 6);
         tp = seg_tab[$urandom_range(0, 1)];
         if (tp == 7'h3F && $urandom_range(0, 1) == 1) tp = 7'h00;
         op = seg_tab[$urandom_range(0, 9)];
         for (int r = 0; r < reps; r++) begin
            logic [6:0] t2, o2;
            t2 = tp;
            o2 = op;
            if ($urandom_range(0, 9) == 0) begin
               kind = $urandom_range(0, 3);
               case (kind)
                  0:       t2 = 7'h5B;
                  1:       t2 = 7'h7E;
                  2:       o2 = 7'h49;
                  default: o2 = 7'h00;
               endcase
            end
            scan("rand", t2, o2, $urandom_range(2, 5), $urandom_range(2, 5),
                 1'($urandom_range(0, 1)));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the two-digit multiplexed 7-segment display drive.
- Watches the segment bus and the digit-select lines and decodes each digit's segment pattern back to BCD.
- Requires the same two-digit reading over several complete scans, then presents the displayed value as binary with a change strobe.
- Used as a loopback checker on the display path and as a front end for reading a display-style interface back into logic.

Parameters:
- STABLE_SCANS, 4: consecutive identical complete scans required before the output value updates (range 1..15).
- SEL_TENS, 2'b10: select-line code that enables the tens digit.
- SEL_ONES, 2'b01: select-line code that enables the ones digit.
- SEG_ACTIVE_HIGH, 1: 1 means a lit segment is a 1 on the bus; 0 means the bus is inverted before decoding.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- led_signal  in  7  segment bus {g,f,e,d,c,b,a}; bit0 = a.
- select_led  in  2  digit-select lines.
- value  out  5  decoded displayed number in binary, tens*10+ones; range 0..19 is valid.
- bcd_tens  out  4  decoded tens digit.
- bcd_ones  out  4  decoded ones digit.
- valid  out  1  one-cycle pulse when value/bcd outputs change.
- locked  out  1  high once the first stable reading has been committed.
- seg_err  out  1  one-cycle pulse on an undecodable pattern or a tens digit > 1.

Behaviour:
- Reset (asynchronous, any time, including mid-scan): value=0, bcd_tens=0, bcd_ones=0, valid=0, locked=0, seg_err=0. The FSM goes to IDLE, and stable count, candidate digits and input registers all clear.
- Input stage: led_signal and select_led are registered once. Decoding uses registered data only, so decode latency from the bus is 1 cycle.
- Settle rule: a digit is sampled only when the registered select_led has held the same code for 2 consecutive cycles. The sample is taken on the second cycle. This rejects the half-cycle segment lag at select transitions.
- Select codes other than SEL_TENS or SEL_ONES are ignored and reset the settle counter.
- Decode table (active-high form): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex). Any other pattern is an error.
- Tens digit 0 is accepted both as 3F and as 00 (blanked leading zero); either decodes to 0.
- FSM states:
  - IDLE: wait for a settled tens sample, then go to GOT_TENS.
  - GOT_TENS: hold the tens candidate and wait for a settled ones sample, then go to COMPARE.
  - A settled tens sample seen in GOT_TENS replaces the candidate and stays in GOT_TENS.
  - A settled ones sample seen in IDLE is discarded; a scan always starts with tens.
  - COMPARE (1 cycle):
    - If the pair equals the previous pair, stable count increments, saturating at STABLE_SCANS.
    - Otherwise stable count = 1 and the previous pair is replaced.
    - Return to IDLE.
- Commit: when stable count reaches STABLE_SCANS in COMPARE, and the pair differs from the outputs or locked=0:
  - Outputs update on the next edge.
  - valid pulses for exactly 1 cycle.
  - locked goes to 1.
  - If the pair equals the outputs, nothing changes and there is no pulse.
- Value arithmetic: value = tens*10 + ones, unsigned, 5 bits. The largest representable input (tens=1, ones=9) gives 19.
- Error handling: an invalid pattern, or a decoded tens > 1:
  - pulses seg_err for 1 cycle;
  - discards the current scan (FSM to IDLE, stable count = 0);
  - leaves the outputs and locked unchanged.
- Simultaneous events: an error in the same cycle as a would-be commit suppresses the commit.

Test Plan:
1. Reset: assert rst mid-scan with locked=1 -> all outputs 0 within the same cycle, locked=0. No valid pulse after release until 4 new stable scans.
2. Steady display of 17: tens=06, ones=07, 4-cycle dwell per digit -> valid pulses once at the end of the 4th complete scan, value=17, bcd_tens=1, bcd_ones=7. No further pulses over 20 scans.
3. Change 17 -> 18 -> 19 -> 00: ones pattern changes 07 -> 7F -> 6F, then tens 3F and ones 3F -> exactly one valid pulse per value, each after 4 scans. Final value=0 (wrap observed).
4. Glitch rejection:
   - Single-cycle select pulses with a wrong segment pattern at each select edge -> no seg_err, value unaffected.
   - One scan of 12 inside a run of 11s -> no output change, and the stable count restarts.
5. Errors:
   - Ones pattern 7'h49 -> seg_err pulses once, scan discarded, value holds.
   - Tens pattern 5B (digit 2) -> seg_err pulse, value holds.
6. Polarity: SEG_ACTIVE_HIGH=0 with inverted patterns for 09 (tens=00 blanked form inverted = 7F, ones=10) -> value=9 after 4 scans.
